// File: rtl/pbuf_free_list_pkg.sv
// rtl/pbuf_free_list_pkg.sv - shared constants and state encoding for the packet buffer free list
package pbuf_free_list_pkg;

  localparam int pb_lines = 64;
  localparam int pb_items = pb_lines;
  localparam int pb_asz   = $clog2(pb_items);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fl_state_e;

endpackage

// File: rtl/pbuf_fl_fifo.sv
// rtl/pbuf_fl_fifo.sv - flop-array FIFO of free line ids with wrapping pointers and occupancy count
module pbuf_fl_fifo #(
  parameter int items = 64,
  parameter int asz   = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [asz-1:0] push_data,
  input  logic           pop,
  output logic [asz-1:0] rd_data,
  output logic [asz:0]   count
);

  localparam logic [asz:0] full_cnt = (asz+1)'(items);

  logic [asz-1:0] mem [items];
  logic [asz-1:0] rd_ptr;
  logic [asz-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (asz+1)'(push) - (asz+1)'(pop);
    end
  end

  // Storage needs no reset; nothing is read before INIT has written it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign rd_data = mem[rd_ptr];

  a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
    !(pop && !push && count == '0));
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count == full_cnt));

endmodule

// File: rtl/pbuf_free_list.sv
// rtl/pbuf_free_list.sv - packet buffer free-line manager with init fill, alloc bitmap and double-free flag
module pbuf_free_list
  import pbuf_free_list_pkg::*;
#(
  parameter int items = pb_items,
  parameter int asz   = $clog2(items)
) (
  input  logic           clk,
  input  logic           reset,
  output logic           p_srdy,
  input  logic           p_drdy,
  output logic [asz-1:0] p_itemid,
  input  logic           f_srdy,
  output logic           f_drdy,
  input  logic [asz-1:0] f_itemid,
  output logic           init_done,
  output logic [asz:0]   free_cnt,
  output logic           dbl_free
);

  localparam logic [asz:0] full_cnt = (asz+1)'(items);

  fl_state_e      state;
  logic [asz-1:0] init_cnt;
  logic [items-1:0] bitmap;
  logic [asz:0]   count;
  logic [asz-1:0] rd_data;
  logic           run;
  logic           do_pop;
  logic           do_free;
  logic           free_ok;
  logic           push;
  logic [asz-1:0] push_data;

  assign run       = (state == RUN);
  assign p_srdy    = reset & run & (count != '0);
  assign f_drdy    = reset & run & (count != full_cnt);
  assign p_itemid  = rd_data;
  assign init_done = reset & run;
  assign free_cnt  = reset ? count : '0;

  // Bitmap is checked with its pre-cycle value, so freeing the id being popped is a double-free.
  assign do_pop    = p_srdy & p_drdy;
  assign do_free   = f_srdy & f_drdy;
  assign free_ok   = do_free & bitmap[f_itemid];
  assign push      = run ? free_ok : 1'b1;
  assign push_data = run ? f_itemid : init_cnt;

  pbuf_fl_fifo #(
    .items (items),
    .asz   (asz)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (do_pop),
    .rd_data   (rd_data),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
      bitmap   <= '0;
      dbl_free <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == asz'(items - 1)) state <= RUN;
    end else begin
      if (do_free && !bitmap[f_itemid]) dbl_free <= 1'b1;
      if (free_ok) bitmap[f_itemid] <= 1'b0;
      if (do_pop)  bitmap[p_itemid] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pbuf_free_list.sv
// tb/tb_pbuf_free_list.sv - randomized self-checking bench for pbuf_free_list against a queue model
module tb_pbuf_free_list;

  localparam int N = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         p_srdy;
  logic         p_drdy;
  logic [A-1:0] p_itemid;
  logic         f_srdy;
  logic         f_drdy;
  logic [A-1:0] f_itemid;
  logic         init_done;
  logic [A:0]   free_cnt;
  logic         dbl_free;

  always #5 clk = ~clk;

  pbuf_free_list #(.items(N), .asz(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_srdy    (p_srdy),
    .p_drdy    (p_drdy),
    .p_itemid  (p_itemid),
    .f_srdy    (f_srdy),
    .f_drdy    (f_drdy),
    .f_itemid  (f_itemid),
    .init_done (init_done),
    .free_cnt  (free_cnt),
    .dbl_free  (dbl_free)
  );

  int errs   = 0;
  int checks = 0;

  int m_q[$];
  bit m_alloc[N];
  bit m_dbl      = 1'b0;
  bit m_run      = 1'b0;
  int m_init_left = N;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int exp_cnt;
    exp_cnt = m_run ? m_q.size() : (N - m_init_left);
    chk("p_srdy", 32'(p_srdy), 32'(m_run && m_q.size() != 0));
    if (m_run && m_q.size() != 0) chk("p_itemid", 32'(p_itemid), 32'(m_q[0]));
    chk("f_drdy", 32'(f_drdy), 32'(m_run && m_q.size() != N));
    chk("init_done", 32'(init_done), 32'(m_run));
    chk("free_cnt", 32'(free_cnt), 32'(exp_cnt));
    chk("dbl_free", 32'(dbl_free), 32'(m_dbl));
  endtask

  task automatic step(input bit rst_n, input bit pd, input bit fs, input int fid);
    bit pop;
    bit fr;
    bit ok;
    int pid;
    reset    = rst_n;
    p_drdy   = pd;
    f_srdy   = fs;
    f_itemid = fid[A-1:0];
    if (!rst_n) begin
      #1;
      chk("rst_p_srdy", 32'(p_srdy), 32'd0);
      chk("rst_f_drdy", 32'(f_drdy), 32'd0);
      m_q.delete();
      for (int i = 0; i < N; i++) m_alloc[i] = 1'b0;
      m_dbl = 1'b0;
      m_run = 1'b0;
      m_init_left = N;
    end else if (!m_run) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_run = 1'b1;
        for (int i = 0; i < N; i++) m_q.push_back(i);
      end
    end else begin
      pop = pd && (m_q.size() != 0);
      fr  = fs && (m_q.size() != N);
      ok  = fr && m_alloc[fid];
      pid = pop ? m_q[0] : 0;
      if (pop) void'(m_q.pop_front());
      if (ok) begin
        m_q.push_back(fid);
        m_alloc[fid] = 1'b0;
      end
      if (fr && !ok) m_dbl = 1'b1;
      if (pop) m_alloc[pid] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int fid;
    reset = 1'b0; p_drdy = 1'b0; f_srdy = 1'b0; f_itemid = '0;

    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 0);
      if (i == N - 2) chk("init_not_early", 32'(init_done), 32'd0);
    end
    chk("init_done_at_8", 32'(init_done), 32'd1);
    chk("init_free_cnt", 32'(free_cnt), 32'd8);
    chk("init_first_id", 32'(p_itemid), 32'd0);

    for (int i = 0; i < N; i++) step(1, 1, 0, 0);
    chk("drained_srdy", 32'(p_srdy), 32'd0);

    step(1, 0, 1, 5);
    chk("refree_id", 32'(p_itemid), 32'd5);
    chk("refree_cnt", 32'(free_cnt), 32'd1);
    step(1, 0, 1, 5);
    chk("dbl_set", 32'(dbl_free), 32'd1);
    chk("dbl_cnt", 32'(free_cnt), 32'd1);
    step(1, 0, 0, 0);

    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 1, 1, 2);
    chk("swap_cnt", 32'(free_cnt), 32'd3);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("swap_last_id", 32'(p_itemid), 32'd2);
    step(1, 1, 0, 0);

    step(1, 1, 1, 3);
    step(0, 1, 1, 3);
    chk("rst_dbl_clr", 32'(dbl_free), 32'd0);
    repeat (N) step(1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(1, 1, 0, 0);

    for (int c = 0; c < 400; c++) begin
      fid = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) != 0) begin
        for (int t = 0; t < 4 && !m_alloc[fid]; t++) fid = $urandom_range(0, N - 1);
      end
      step($urandom_range(0, 149) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, fid);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
